// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller; registered outputs reflect the state entered on the same edge.
// SEG_SCAN_DIM_EN adds a 3-bit dim input that shortens the lit part of each drive phase.
module seg_scan_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_en,
  input  logic [6:0] in0,
  input  logic [6:0] in1,
  input  logic [6:0] in2,
  input  logic [6:0] in3,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0] dim,
`endif
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic [1:0] cur_digit,
  output logic       frame_start
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  // With no dead time, every slot starts directly in DRIVE.
  localparam state_t SLOT_FIRST = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    shadow_q, shadow_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic [3:0]    an_n_q, an_n_d;
  logic [1:0]    cur_q, cur_d;
  logic          fs_q, fs_d;
  logic          capture;
  logic          lit;
  logic [6:0]    pat_sel;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]    dim_q, dim_d;
  int            lit_len;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = IDLE;
      tick_d  = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = SLOT_FIRST;
      tick_d  = '0;
      idx_d   = '0;
    end else if (tick_q == TICK_LAST) begin
      state_d = SLOT_FIRST;
      tick_d  = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      tick_d  = tick_q + 1'b1;
      state_d = (int'(tick_d) < BLANK_CYCLES) ? BLANK : DRIVE;
    end

    case (idx_d)
      2'd0:    pat_sel = in0;
      2'd1:    pat_sel = in1;
      2'd2:    pat_sel = in2;
      default: pat_sel = in3;
    endcase

    // The pattern is frozen on the edge that enters the drive phase of a slot.
    capture  = (state_d == DRIVE) && (int'(tick_d) == BLANK_CYCLES);
    shadow_d = capture ? pat_sel : shadow_q;

`ifdef SEG_SCAN_DIM_EN
    dim_d   = capture ? dim : dim_q;
    lit_len = ((TICK_DIV - BLANK_CYCLES) * (int'(dim_d) + 1)) >> 3;
    lit     = (int'(tick_d) - BLANK_CYCLES) < lit_len;
`else
    lit     = 1'b1;
`endif

    seg_n_d = 7'h7F;
    an_n_d  = 4'hF;
    if (state_d == DRIVE && lit) begin
      seg_n_d = ~shadow_d;
      if (digit_en[idx_d]) an_n_d = ~(4'b0001 << idx_d);
    end
    cur_d = idx_d;
    fs_d  = (state_d != IDLE) && (idx_d == 2'd0) && (tick_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_n_q  <= 7'h7F;
      an_n_q   <= 4'hF;
      cur_q    <= '0;
      fs_q     <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      dim_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_n_q  <= seg_n_d;
      an_n_q   <= an_n_d;
      cur_q    <= cur_d;
      fs_q     <= fs_d;
`ifdef SEG_SCAN_DIM_EN
      dim_q    <= dim_d;
`endif
    end
  end

  assign seg_n       = seg_n_q;
  assign an_n        = an_n_q;
  assign cur_digit   = cur_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] digit_en;
  logic [6:0] in0, in1, in2, in3;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic [1:0] cur_digit;
  logic       frame_start;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  seg_scan_ctrl #(.TICK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .digit_en    (digit_en),
    .in0         (in0),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
`ifdef SEG_SCAN_DIM_EN
    .dim         (3'd7),
`endif
    .seg_n       (seg_n),
    .an_n        (an_n),
    .cur_digit   (cur_digit),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic run_to(input int t);
    while (n < t) cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s @edge %0d: observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    digit_en = 4'hF;
    in0 = 7'h3F; in1 = 7'h06; in2 = 7'h5B; in3 = 7'h66;

    repeat (3) cyc();
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_an", an_n, 4'hF);
    chk("rst_cur", cur_digit, 2'd0);
    chk("rst_fs", frame_start, 1'b0);

    // Edge numbering restarts so that edge 1 is the first edge after release.
    rst_n = 1'b1;
    n = 0;
    run_to(1);
    chk("start_fs", frame_start, 1'b1);
    chk("start_an", an_n, 4'hF);
    chk("start_seg", seg_n, 7'h7F);
    run_to(2);
    chk("blank1_fs", frame_start, 1'b0);
    chk("blank1_an", an_n, 4'hF);
    for (int e = 3; e <= 8; e++) begin
      run_to(e);
      chk("s0_an", an_n, 4'b1110);
      chk("s0_seg", seg_n, 7'h40);
    end
    run_to(9);
    chk("s1_blank_an", an_n, 4'hF);
    chk("s1_cur", cur_digit, 2'd1);
    chk("s1_fs", frame_start, 1'b0);
    run_to(11);
    chk("s1_an", an_n, 4'b1101);
    chk("s1_seg", seg_n, 7'h79);
    run_to(17);
    chk("s2_fs", frame_start, 1'b0);
    chk("s2_cur", cur_digit, 2'd2);
    run_to(19);
    chk("s2_an", an_n, 4'b1011);
    chk("s2_seg", seg_n, 7'h24);
    run_to(21);
    in2 = 7'h4F;
    for (int e = 22; e <= 24; e++) begin
      run_to(e);
      chk("shadow_hold", seg_n, 7'h24);
    end
    run_to(27);
    chk("s3_an", an_n, 4'b0111);
    chk("s3_seg", seg_n, 7'h19);
    run_to(32);
    chk("frame_end_fs", frame_start, 1'b0);
    run_to(33);
    chk("frame2_fs", frame_start, 1'b1);
    chk("frame2_cur", cur_digit, 2'd0);
    run_to(51);
    chk("shadow_new", seg_n, 7'h30);

    run_to(64);
    digit_en = 4'b0101;
    run_to(65);
    chk("gate_fs", frame_start, 1'b1);
    run_to(67);
    chk("gate_s0_an", an_n, 4'b1110);
    for (int e = 73; e <= 80; e++) begin
      run_to(e);
      chk("gate_s1_an", an_n, 4'hF);
    end
    run_to(83);
    chk("gate_s2_an", an_n, 4'b1011);
    for (int e = 89; e <= 96; e++) begin
      run_to(e);
      chk("gate_s3_an", an_n, 4'hF);
      chk("gate_s3_fs", frame_start, 1'b0);
    end
    run_to(97);
    chk("gate_period_fs", frame_start, 1'b1);
    digit_en = 4'hF;

    run_to(116);
    chk("en_drive_an", an_n, 4'b1011);
    en = 1'b0;
    run_to(117);
    chk("en_off_an", an_n, 4'hF);
    chk("en_off_seg", seg_n, 7'h7F);
    chk("en_off_cur", cur_digit, 2'd0);
    chk("en_off_fs", frame_start, 1'b0);
    run_to(118);
    chk("idle_an", an_n, 4'hF);
    en = 1'b1;
    run_to(119);
    chk("en_on_fs", frame_start, 1'b1);
    chk("en_on_an", an_n, 4'hF);
    run_to(120);
    chk("en_on_blank", an_n, 4'hF);
    run_to(121);
    chk("en_on_an0", an_n, 4'b1110);
    chk("en_on_seg0", seg_n, 7'h40);

    run_to(122);
    rst_n = 1'b0;
    run_to(123);
    chk("mid_rst_an", an_n, 4'hF);
    chk("mid_rst_seg", seg_n, 7'h7F);
    chk("mid_rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;
    run_to(124);
    chk("rst_rel_fs", frame_start, 1'b1);
    chk("rst_rel_cur", cur_digit, 2'd0);
    run_to(125);
    chk("rst_rel_blank", an_n, 4'hF);
    run_to(126);
    chk("rst_rel_an0", an_n, 4'b1110);
    chk("rst_rel_seg0", seg_n, 7'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
